// File: rtl/vga_timing.sv
// Purpose : 1280x1024@60 raster timing: pixel/line counters, sync pulses, blanking, frame pulse.
// Latency : one cycle. ce sampled at edge N updates all outputs together after edge N.
// Backpress: none. ce=0 freezes every output and forces frame_start low.
// Optional : define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 48,
    parameter int   H_SYNC   = 112,
    parameter int   H_BP     = 248,
    parameter int   V_ACTIVE = 1024,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 38,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        pixel_clock,
    input  logic        rst_n,
    input  logic        ce,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // Totals must fit the 11-bit counters (<= 2048).
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        hblnk_next;
    logic        vblnk_next;

    // Next raster position and the flags that describe it, so the registered
    // flags always line up with the registered counts.
    always_comb begin
        h_wrap     = (hcount == H_LAST);
        v_wrap     = (vcount == V_LAST);
        h_next     = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next     = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 11'd0 : vcount + 11'd1;
        end
        hsync_next = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_next = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        hblnk_next = (h_next >= H_VIS);
        vblnk_next = (v_next >= V_VIS);
    end

    // Counters advance only on enabled cycles; reset parks at (0,0).
    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= 11'd0;
            vcount <= 11'd0;
        end else if (ce) begin
            hcount <= h_next;
            vcount <= v_next;
        end
    end

    // Sync and blanking flags registered alongside the counters.
    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            hblnk <= 1'b0;
            vblnk <= 1'b0;
        end else if (ce) begin
            hsync <= hsync_next;
            vsync <= vsync_next;
            hblnk <= hblnk_next;
            vblnk <= vblnk_next;
        end
    end

    // Frame pulse only on the enabled wrap into (0,0); never straight out of reset.
    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce && h_wrap && v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Completed-frame count, stepping on the same edge that raises frame_start.
    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (ce && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line-level timing, a shrunken
// negative-sync instance for frame-level timing, both compared every cycle
// against a position-from-cycle-count model.
module tb_vga_timing;

    // Full-size timing constants.
    localparam int BHA = 1280, BHF = 48, BHS = 112, BHB = 248;
    localparam int BVA = 1024, BVF = 1,  BVS = 3,   BVB = 38;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    localparam longint BFR = longint'(BHT) * longint'(BVT);

    // Shrunken timing so whole frames fit in a short run.
    localparam int SHA = 40, SHF = 4, SHS = 6, SHB = 10;
    localparam int SVA = 20, SVF = 1, SVS = 3, SVB = 4;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam longint SFR = longint'(SHT) * longint'(SVT);

    logic        pixel_clock = 1'b0;
    logic        rst_n;
    logic        ce_b, ce_s;
    logic [10:0] hcount_b, vcount_b, hcount_s, vcount_s;
    logic        hsync_b, vsync_b, hblnk_b, vblnk_b, frame_start_b;
    logic        hsync_s, vsync_s, hblnk_s, vblnk_s, frame_start_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_b, frame_cnt_s;
`endif

    longint t_b, t_s;      // enabled cycles since reset
    bit     prev_b, prev_s; // last edge was an enabled, non-reset edge
    int     n_tests = 0;
    int     n_fail  = 0;

    always #5 pixel_clock = ~pixel_clock;

    vga_timing dut_b (
        .pixel_clock (pixel_clock),
        .rst_n       (rst_n),
        .ce          (ce_b),
        .hcount      (hcount_b),
        .vcount      (vcount_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .hblnk       (hblnk_b),
        .vblnk       (vblnk_b),
        .frame_start (frame_start_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt_b)
`endif
    );

    vga_timing #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
        .SYNC_POL (1'b0)
    ) dut_s (
        .pixel_clock (pixel_clock),
        .rst_n       (rst_n),
        .ce          (ce_s),
        .hcount      (hcount_s),
        .vcount      (vcount_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .hblnk       (hblnk_s),
        .vblnk       (vblnk_s),
        .frame_start (frame_start_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt_s)
`endif
    );

    // Raster position is just the enabled-cycle count folded by line and frame length.
    function automatic logic [26:0] model(input longint t, input bit prev,
                                          input int ha, input int hf, input int hs, input int ht,
                                          input int va, input int vf, input int vs, input int vt,
                                          input bit pol);
        longint fr;
        int     h, v;
        bit     hs_on, vs_on, fs;
        fr    = longint'(ht) * longint'(vt);
        h     = int'(t % longint'(ht));
        v     = int'((t / longint'(ht)) % longint'(vt));
        hs_on = (h >= ha + hf) && (h < ha + hf + hs);
        vs_on = (v >= va + vf) && (v < va + vf + vs);
        fs    = prev && (t > 0) && ((t % fr) == 0);
        return {11'(h), 11'(v), hs_on ? pol : ~pol, vs_on ? pol : ~pol,
                (h >= ha), (v >= va), fs};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string name);
        logic [26:0] got, exp;
        got = {hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b, frame_start_b};
        exp = model(t_b, prev_b, BHA, BHF, BHS, BHT, BVA, BVF, BVS, BVT, 1'b1);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s_big: got %h expected %h (t=%0d)", name, got, exp, t_b);
        end
        got = {hcount_s, vcount_s, hsync_s, vsync_s, hblnk_s, vblnk_s, frame_start_s};
        exp = model(t_s, prev_s, SHA, SHF, SHS, SHT, SVA, SVF, SVS, SVT, 1'b0);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s_small: got %h expected %h (t=%0d)", name, got, exp, t_s);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        n_tests++;
        if (frame_cnt_b !== 16'(t_b / BFR) || frame_cnt_s !== 16'(t_s / SFR)) begin
            n_fail++;
            $display("FAIL %s_frame_cnt: got %0d/%0d expected %0d/%0d", name,
                     frame_cnt_b, frame_cnt_s, 16'(t_b / BFR), 16'(t_s / SFR));
        end
`endif
    endtask

    // One clock: drive enables, let the edge happen, advance the model, check at negedge.
    task automatic step(input bit cb, input bit cs);
        ce_b = cb;
        ce_s = cs;
        @(posedge pixel_clock);
        if (rst_n === 1'b1) begin
            t_b = t_b + longint'(cb);
            t_s = t_s + longint'(cs);
        end
        prev_b = (rst_n === 1'b1) && cb;
        prev_s = (rst_n === 1'b1) && cs;
        @(negedge pixel_clock);
        check_all("step");
    endtask

    task automatic run_b_until(input int h);
        int k = 0;
        while (int'(hcount_b) != h && k < 4000) begin
            step(1'b1, 1'b0);
            k++;
        end
        chk("reach_big_h", int'(hcount_b), h);
    endtask

    task automatic run_s_until(input int h, input int v);
        int k = 0;
        while (!(int'(hcount_s) == h && int'(vcount_s) == v) && k < 5000) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("reach_small_pos", int'(hcount_s) * 4096 + int'(vcount_s), h * 4096 + v);
    endtask

    typedef struct { bit ce; int exp_h; } ce_rec_t;
    typedef struct { int h; bit hs; bit hb; } hpos_rec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ce_rec_t   ce_tbl[4];
        hpos_rec_t hp_tbl[8];
        int hb_rise, hb_fall, hs_cnt, hs_first, hs_last;
        int pulses, p1, p2;
        bit prev_hb;

        ce_tbl[0] = '{1'b1, 101};
        ce_tbl[1] = '{1'b0, 101};
        ce_tbl[2] = '{1'b0, 101};
        ce_tbl[3] = '{1'b1, 102};

        hp_tbl[0] = '{1279, 1'b0, 1'b0};
        hp_tbl[1] = '{1280, 1'b0, 1'b1};
        hp_tbl[2] = '{1327, 1'b0, 1'b1};
        hp_tbl[3] = '{1328, 1'b1, 1'b1};
        hp_tbl[4] = '{1439, 1'b1, 1'b1};
        hp_tbl[5] = '{1440, 1'b0, 1'b1};
        hp_tbl[6] = '{1687, 1'b0, 1'b1};
        hp_tbl[7] = '{0,    1'b0, 1'b0};

        // Reset state.
        rst_n = 1'b0; ce_b = 1'b1; ce_s = 1'b1;
        t_b = 0; t_s = 0; prev_b = 1'b0; prev_s = 1'b0;
        repeat (2) @(negedge pixel_clock);
        check_all("reset");
        chk("reset_hsync_big", int'(hsync_b), 0);
        chk("reset_vsync_small", int'(vsync_s), 1);

        // Line advance, hblnk edges and hsync window on the full-size timing.
        rst_n = 1'b1;
        hb_rise = -1; hb_fall = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
        prev_hb = 1'b0;
        for (int i = 0; i < BHT; i++) begin
            step(1'b1, 1'b1);
            if (i == 0) chk("first_edge_h", int'(hcount_b), 1);
            if (hblnk_b && !prev_hb) hb_rise = int'(hcount_b);
            if (!hblnk_b && prev_hb) hb_fall = int'(hcount_b);
            prev_hb = hblnk_b;
            if (hsync_b) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(hcount_b);
                hs_last = int'(hcount_b);
            end
        end
        chk("line_end_h", int'(hcount_b), 0);
        chk("line_end_v", int'(vcount_b), 1);
        chk("hblnk_rise", hb_rise, 1280);
        chk("hblnk_fall", hb_fall, 0);
        chk("hsync_width", hs_cnt, 112);
        chk("hsync_first", hs_first, 1328);
        chk("hsync_last", hs_last, 1439);

        // Clock-enable hold from hcount=100.
        run_b_until(100);
        for (int i = 0; i < 4; i++) begin
            step(ce_tbl[i].ce, 1'b0);
            chk("ce_hold_h", int'(hcount_b), ce_tbl[i].exp_h);
            chk("ce_hold_flags", int'({hsync_b, vsync_b, hblnk_b, vblnk_b, frame_start_b}), 0);
        end

        // Horizontal boundary positions.
        for (int i = 0; i < 8; i++) begin
            run_b_until(hp_tbl[i].h);
            chk("hpos_hsync", int'(hsync_b), int'(hp_tbl[i].hs));
            chk("hpos_hblnk", int'(hblnk_b), int'(hp_tbl[i].hb));
        end

        // Random enables on both instances.
        for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Frame period on the shrunken timing, starting fresh from reset.
        @(negedge pixel_clock);
        rst_n = 1'b0;
        #1;
        t_b = 0; t_s = 0; prev_b = 1'b0; prev_s = 1'b0;
        check_all("reset2");
        @(negedge pixel_clock);
        rst_n = 1'b1;
        pulses = 0; p1 = -1; p2 = -1;
        for (int i = 1; i <= 2 * int'(SFR) + 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1);
            if (frame_start_s) begin
                pulses++;
                if (pulses == 1) p1 = i;
                if (pulses == 2) p2 = i;
                chk("frame_pulse_pos", int'(hcount_s) + int'(vcount_s), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
                chk("frame_cnt_at_pulse", int'(frame_cnt_s), pulses);
`endif
            end
        end
        chk("frame_pulses", pulses, 2);
        chk("frame_first_pulse", p1, int'(SFR));
        chk("frame_spacing", p2 - p1, int'(SFR));

        // Vertical blanking and sync edges (active-low sync on this instance).
        run_s_until(SHT - 1, SVA - 1);
        chk("vblnk_before", int'(vblnk_s), 0);
        step(1'b0, 1'b1);
        chk("vblnk_on", int'(vblnk_s), 1);
        run_s_until(SHT - 1, SVA + SVF - 1);
        chk("vsync_before", int'(vsync_s), 1);
        step(1'b0, 1'b1);
        chk("vsync_first", int'(vsync_s), 0);
        run_s_until(SHT - 1, SVA + SVF + SVS - 1);
        chk("vsync_last", int'(vsync_s), 0);
        step(1'b0, 1'b1);
        chk("vsync_off", int'(vsync_s), 1);
        run_s_until(SHT - 1, SVT - 1);
        chk("vblnk_last", int'(vblnk_s), 1);
        step(1'b0, 1'b1);
        chk("vblnk_off", int'(vblnk_s), 0);
        chk("wrap_frame_start", int'(frame_start_s), 1);
        chk("wrap_v", int'(vcount_s), 0);

        // More random enables.
        for (int i = 0; i < 4000; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Reset mid-frame while inside both sync pulses.
        run_s_until(SHA + SHF + 2, SVA + SVF + 1);
        chk("pre_reset_hsync", int'(hsync_s), 0);
        rst_n = 1'b0;
        #1;
        t_b = 0; t_s = 0; prev_b = 1'b0; prev_s = 1'b0;
        check_all("midreset");
        chk("midreset_hsync", int'(hsync_s), 1);
        chk("midreset_vsync", int'(vsync_s), 1);
        step(1'b1, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        chk("restart_h_big", int'(hcount_b), 1);
        chk("restart_h_small", int'(hcount_s), 1);
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the raster timing for the 1280x1024@60 Hz VGA output: horizontal and vertical pixel counters, sync pulses and blanking flags. It sits directly upstream of every raster consumer, including the end-of-frame interrupt generator, the sprite/background renderers and the VGA pins, and drives their `hcount_in`/`vcount_in`. All outputs are registered and mutually aligned, so downstream stages see one coherent pixel position per cycle.

## Interface

**Parameters**

- `H_ACTIVE`, 1280, visible pixels per line.
- `H_FP`, 48, horizontal front porch in pixels.
- `H_SYNC`, 112, horizontal sync width in pixels.
- `H_BP`, 248, horizontal back porch in pixels. `H_TOTAL` = 1688.
- `V_ACTIVE`, 1024, visible lines.
- `V_FP`, 1, vertical front porch in lines.
- `V_SYNC`, 3, vertical sync width in lines.
- `V_BP`, 38, vertical back porch in lines. `V_TOTAL` = 1066.
- `SYNC_POL`, 1, active level of `hsync`/`vsync` (1 = positive).

**Ports**

- `pixel_clock`, input, 1, pixel clock (108 MHz).
- `rst_n`, input, 1, asynchronous active-low reset.
- `ce`, input, 1, pixel enable; the counters advance only when it is 1.
- `hcount`, output, 11, current pixel column, 0..H_TOTAL-1.
- `vcount`, output, 11, current line, 0..V_TOTAL-1.
- `hsync`, output, 1, horizontal sync at level `SYNC_POL`.
- `vsync`, output, 1, vertical sync at level `SYNC_POL`.
- `hblnk`, output, 1, 1 when `hcount` >= H_ACTIVE.
- `vblnk`, output, 1, 1 when `vcount` >= V_ACTIVE.
- `frame_start`, output, 1, one-cycle pulse when the counters wrap to (0,0).
- `frame_cnt`, output, 16, frames completed. Present only with `VGA_TIMING_FRAME_CNT_EN`.

## Operation

- **Horizontal counter.** When `ce`=1, `hcount` increments. At H_TOTAL-1 it wraps to 0.
- **Vertical counter.** `vcount` increments only on the cycle where `hcount` wraps. At V_TOTAL-1 on that same cycle it wraps to 0.
- **Holding.** When `ce`=0, every output holds its value, and `frame_start` is 0.
- **Sync and blanking decode.** These are decoded from the next-state counter values and registered, so they always describe the `hcount`/`vcount` presented in the same cycle.
  - `hsync` is active for `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is [1328, 1439].
  - `vsync` is active for `vcount` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is [1025, 1027], for whole lines including `hcount`=0.
  - `hblnk` and `vblnk` are independent. A pixel is visible iff both are 0.
- **Frame start.** `frame_start`=1 exactly in the cycle in which the counters transition from (H_TOTAL-1, V_TOTAL-1) to (0,0) with `ce`=1. It is not asserted for the (0,0) state that immediately follows reset.
- **Width.** All compares use 11-bit unsigned arithmetic. The parameter sums must satisfy H_TOTAL <= 2048 and V_TOTAL <= 2048.

## Timing

- **Reset values** (asynchronous, effective immediately):
  - `hcount`=0, `vcount`=0, `hblnk`=0, `vblnk`=0, `frame_start`=0, `frame_cnt`=0.
  - `hsync`=`vsync`=~SYNC_POL, i.e. inactive.
- **Reset release.** The first rising edge with `rst_n`=1 and `ce`=1 produces `hcount`=1.
- **Reset mid-frame.** Reset asserted mid-frame forces the reset values at once. There is no partial-line completion.
- **Latency.** `ce` sampled high at edge N changes the outputs after edge N. All outputs update on the same edge, with zero skew between the counts and the flags.
- **Line and frame length.** One line is 1688 enabled cycles. One frame is 1,799,408 enabled cycles.
- **Simultaneous wraps.** A simultaneous horizontal and vertical wrap is a single event: `vcount` goes to 0 (not 1066), and `frame_start` pulses.

## Configuration

- **`VGA_TIMING_FRAME_CNT_EN` defined.**
  - The `frame_cnt` port exists.
  - It increments by 1 on each cycle with `frame_start`=1, wraps 0xFFFF to 0x0000, and resets to 0.
- **Not defined.**
  - The port and the counter are absent.
  - All other behaviour is identical.

## Test plan

- **Line advance.** Release reset with `ce`=1 and run 1688 clocks -> `hcount`=0, `vcount`=1; `hblnk` rises exactly at `hcount`=1280 and falls at 0.
- **Horizontal sync.** Measure `hsync` -> active for exactly 112 cycles, first at `hcount`=1328 and last at 1439; inactive at 1327 and 1440.
- **Vertical sync.** Run to `vcount`=1025, `hcount`=0 -> `vsync` active. It stays active through `vcount`=1027, `hcount`=1687, then goes inactive. `vblnk`=1 from `vcount`=1024 to 1065.
- **Frame period.** Run two frames -> `frame_start` pulses are exactly 1,799,408 cycles apart, each coinciding with `hcount`=`vcount`=0. There is no pulse right after reset. With the macro, `frame_cnt` reads 1 and then 2.
- **Clock enable.** Toggle `ce` 1,0,0,1 starting from `hcount`=100 -> `hcount` reads 101,101,101,102, and all flags are stable during `ce`=0.
- **Reset mid-frame.** Assert `rst_n`=0 at `hcount`=1400, `vcount`=1026 -> outputs go immediately to 0/0 with `hsync`=`vsync` inactive. After release the count restarts from 0.
